// File: rtl/uart_receiver.sv
// UART receive path: start + DATA_BITS (LSB first) + even parity + stop, sampled on an OVERSAMPLE x baud tick.
// Optional build macro UART_RX_MAJORITY_VOTE_EN: each bit decision takes a 2-of-3 vote over the last three ticks.
module uart_receiver #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 rx_en,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_perror,
  output logic                 rx_ferror,
  output logic                 rx_busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] START_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_MID   = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 line_seen_high_q, line_seen_high_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_perror_q, rx_perror_d;
  logic                 rx_ferror_q, rx_ferror_d;
  logic                 rxd_meta_q, rxd_s_q;
  logic                 sample;

`ifdef UART_RX_MAJORITY_VOTE_EN
  // The two previous tick samples plus the current one form the three-sample window.
  logic [1:0] vote_q, vote_d;
  assign sample = (vote_q[1] & vote_q[0]) | (vote_q[1] & rxd_s_q) | (vote_q[0] & rxd_s_q);
  always_comb vote_d = sample_tick ? {vote_q[0], rxd_s_q} : vote_q;
`else
  assign sample = rxd_s_q;
`endif

  always_comb begin
    // NOTE: every _d gets a default first so no path through this block can infer a latch.
    state_d          = state_q;
    tick_cnt_d       = tick_cnt_q;
    bit_idx_d        = bit_idx_q;
    shift_d          = shift_q;
    parity_d         = parity_q;
    line_seen_high_d = line_seen_high_q;
    rx_data_d        = rx_data_q;
    rx_valid_d       = 1'b0;
    rx_perror_d      = 1'b0;
    rx_ferror_d      = 1'b0;

    if (!rx_en) begin
      state_d          = IDLE;
      tick_cnt_d       = '0;
      bit_idx_d        = '0;
      line_seen_high_d = 1'b0;
    end else if (sample_tick) begin
      case (state_q)
        IDLE: begin
          // A falling edge only counts after the line was seen idle, so a held break cannot retrigger.
          if (rxd_s_q) begin
            line_seen_high_d = 1'b1;
          end else if (line_seen_high_q) begin
            state_d          = START;
            tick_cnt_d       = '0;
            line_seen_high_d = 1'b0;
          end
        end
        START: begin
          if (tick_cnt_q == START_MID) begin
            tick_cnt_d = '0;
            bit_idx_d  = '0;
            state_d    = sample ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        DATA, PARITY, STOP: begin
          if (tick_cnt_q != BIT_MID) begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end else begin
            tick_cnt_d = '0;
            if (state_q == DATA) begin
              shift_d[bit_idx_q] = sample;
              if (bit_idx_q == LAST_BIT) state_d = PARITY;
              else                       bit_idx_d = bit_idx_q + BW'(1);
            end else if (state_q == PARITY) begin
              parity_d = sample;
              state_d  = STOP;
            end else begin
              state_d = IDLE;
              if (!sample) begin
                rx_ferror_d = 1'b1;
              end else begin
                rx_data_d = shift_q;
                if (parity_q != ^shift_q) rx_perror_d = 1'b1;
                else                      rx_valid_d  = 1'b1;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of statement order.
    if (reset) begin
      rxd_meta_q       <= 1'b1;
      rxd_s_q          <= 1'b1;
      state_q          <= IDLE;
      tick_cnt_q       <= '0;
      bit_idx_q        <= '0;
      shift_q          <= '0;
      parity_q         <= 1'b0;
      line_seen_high_q <= 1'b0;
      rx_data_q        <= '0;
      rx_valid_q       <= 1'b0;
      rx_perror_q      <= 1'b0;
      rx_ferror_q      <= 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
      vote_q           <= 2'b11;
`endif
    end else begin
      rxd_meta_q       <= rxd;
      rxd_s_q          <= rxd_meta_q;
      state_q          <= state_d;
      tick_cnt_q       <= tick_cnt_d;
      bit_idx_q        <= bit_idx_d;
      shift_q          <= shift_d;
      parity_q         <= parity_d;
      line_seen_high_q <= line_seen_high_d;
      rx_data_q        <= rx_data_d;
      rx_valid_q       <= rx_valid_d;
      rx_perror_q      <= rx_perror_d;
      rx_ferror_q      <= rx_ferror_d;
`ifdef UART_RX_MAJORITY_VOTE_EN
      vote_q           <= vote_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_perror = rx_perror_q;
  assign rx_ferror = rx_ferror_q;
  assign rx_busy   = (state_q != IDLE);
endmodule
